// File: rtl/alu_accum_reg_if.sv
// Handshake/operand bundle for alu_accum_reg.
// Optional: ALU_FLAGS_EN adds the {negative, zero} flags signal.
interface alu_accum_reg_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0]   a;
    logic [2:0]         op;
    logic               start;
    logic [2*WIDTH-1:0] result;
    logic               busy;
    logic               done;
`ifdef ALU_FLAGS_EN
    logic [1:0]         flags;
`endif

    modport master (
        output a, op, start,
        input  result, busy, done
`ifdef ALU_FLAGS_EN
        , input flags
`endif
    );

    modport slave (
        input  a, op, start,
        output result, busy, done
`ifdef ALU_FLAGS_EN
        , output flags
`endif
    );
endinterface

// File: rtl/alu_accum_reg.sv
// Accumulator ALU: operand B is the low half of the result register; op 5 is a
// multi-cycle shift-add multiply. Optional macro ALU_FLAGS_EN adds {negative, zero}.
module alu_accum_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    alu_accum_reg_if.slave bus
);
    localparam int unsigned RW  = 2 * WIDTH;
    localparam int unsigned SHW = $clog2(RW);
    localparam int unsigned CW  = $clog2(WIDTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    logic [0:0]       state, state_n;
    logic [RW-1:0]    result, result_n;
    logic             busy, busy_n;
    logic             done, done_n;
    logic [WIDTH-1:0] mcand, mcand_n;
    logic [WIDTH-1:0] mplier, mplier_n;
    logic [RW-1:0]    acc, acc_n;
    logic [CW-1:0]    count, count_n;
    logic             write_c;
    logic [RW-1:0]    alu_c;
    logic [WIDTH-1:0] b_c;

    assign b_c = result[WIDTH-1:0];

    // Single-cycle operation results, all formed at full result width.
    always_comb begin
        alu_c = result;
        case (bus.op)
            3'd0:    alu_c = RW'(bus.a) + RW'(b_c);
            3'd1:    alu_c = RW'(bus.a) - RW'(b_c);
            3'd2:    alu_c = {~(bus.a & b_c), ~(bus.a ^ b_c)};
            3'd3:    alu_c = (|{bus.a, b_c}) ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}} : '0;
            3'd4:    alu_c = RW'(b_c) << bus.a[SHW-1:0];
            3'd6:    alu_c = result;
            3'd7:    alu_c = '0;
            default: alu_c = result;
        endcase
    end

    // Next-state and register-update logic for the handshake and multiply sequencer.
    always_comb begin
        state_n  = state;
        result_n = result;
        busy_n   = busy;
        done_n   = 1'b0;
        mcand_n  = mcand;
        mplier_n = mplier;
        acc_n    = acc;
        count_n  = count;
        write_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op == 3'd5) begin
                        mcand_n  = bus.a;
                        mplier_n = b_c;
                        acc_n    = '0;
                        count_n  = '0;
                        busy_n   = 1'b1;
                        state_n  = MUL;
                    end else begin
                        result_n = alu_c;
                        done_n   = 1'b1;
                        write_c  = 1'b1;
                    end
                end
            end
            MUL: begin
                if (mplier[count]) begin
                    acc_n = acc + (RW'(mcand) << count);
                end
                count_n = count + CW'(1);
                if (count == CW'(WIDTH - 1)) begin
                    result_n = acc_n;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                    write_c  = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            state  <= state_n;
            result <= result_n;
            busy   <= busy_n;
            done   <= done_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            acc    <= acc_n;
            count  <= count_n;
        end
    end

`ifdef ALU_FLAGS_EN
    logic [1:0] flags;

    // Flags track every result write, including a hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            flags <= 2'b01;
        end else if (write_c) begin
            flags <= {result_n[RW-1], (result_n == '0)};
        end
    end

    assign bus.flags = flags;
`endif

    assign bus.result = result;
    assign bus.busy   = busy;
    assign bus.done   = done;
endmodule

// File: tb/tb_alu_accum_reg.sv
// Directed plus randomized check of alu_accum_reg against an arithmetic reference model.
module tb_alu_accum_reg;
    localparam int unsigned W  = 4;
    localparam int          RM = (1 << (2 * W)) - 1;
    localparam int          WM = (1 << W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   m_res  = 0;

    alu_accum_reg_if #(.WIDTH(W)) bus ();

    alu_accum_reg #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
`ifdef ALU_FLAGS_EN
        int exp_f;
        exp_f = ((m_res >> (2 * W - 1)) & 1) * 2 + ((m_res == 0) ? 1 : 0);
        check(tag, int'(bus.flags), exp_f);
`else
        checks = checks + 0;
`endif
    endtask

    // Reference behaviour of each op on integers.
    function automatic int model(input int o, input int av, input int b, input int r);
        case (o)
            0: return (av + b) & RM;
            1: return (av - b) & RM;
            2: return (((~(av & b)) & WM) * (1 << W)) | ((~(av ^ b)) & WM);
            3: return ((av != 0) || (b != 0)) ? WM : 0;
            4: return (b * (1 << (av % (2 * W)))) & RM;
            5: return av * b;
            6: return r;
            default: return 0;
        endcase
    endfunction

    task automatic do_op(input int o, input int av, input bit poke_busy);
        int exp;
        exp = model(o, av, m_res & WM, m_res);
        bus.op    = 3'(o);
        bus.a     = W'(av);
        bus.start = 1'b1;
        step();
        if (o == 5) begin
            for (int k = 0; k < int'(W); k++) begin
                check("mul_busy", int'(bus.busy), 1);
                check("mul_hold", int'(bus.result), m_res);
                check("mul_nodone", int'(bus.done), 0);
                bus.start = poke_busy;
                bus.op    = 3'($urandom_range(0, 7));
                bus.a     = W'($urandom);
                step();
            end
        end
        bus.start = 1'b0;
        m_res = exp;
        check($sformatf("op%0d_result", o), int'(bus.result), exp);
        check($sformatf("op%0d_done", o), int'(bus.done), 1);
        check($sformatf("op%0d_busy", o), int'(bus.busy), 0);
        check_flags($sformatf("op%0d_flags", o));
    endtask

    initial begin
        bus.a     = '0;
        bus.op    = '0;
        bus.start = 1'b0;
        reset     = 1'b1;
        step();
        step();
        reset = 1'b0;
        m_res = 0;
        check("rst_result", int'(bus.result), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check_flags("rst_flags");

        // Back-to-back adds, then idle cycle must hold and drop done.
        do_op(0, 5, 1'b0);
        do_op(0, 3, 1'b0);
        check("add_chain", int'(bus.result), 8'h08);
        step();
        check("idle_done", int'(bus.done), 0);
        check("idle_hold", int'(bus.result), 8'h08);

        // Multiply with ignored starts during busy, then a start in the done cycle.
        do_op(7, 0, 1'b0);
        do_op(0, 7, 1'b0);
        do_op(5, 6, 1'b1);
        check("mul_value", int'(bus.result), 8'h2A);
        do_op(7, 0, 1'b0);
        do_op(0, 7, 1'b0);
        do_op(1, 3, 1'b0);
        check("sub_wrap", int'(bus.result), 8'hFC);
        do_op(7, 0, 1'b0);
        do_op(0, 12, 1'b0);
        do_op(2, 10, 1'b0);
        check("logic_op", int'(bus.result), 8'h79);
        do_op(7, 0, 1'b0);
        do_op(3, 0, 1'b0);
        check("or_zero", int'(bus.result), 8'h00);
        do_op(3, 1, 1'b0);
        do_op(4, 4, 1'b0);
        check("shift", int'(bus.result), 8'hF0);
        do_op(6, 9, 1'b0);
        check("hold_op", int'(bus.result), 8'hF0);

        // Reset on the second busy cycle aborts the multiply.
        do_op(7, 0, 1'b0);
        do_op(0, 3, 1'b0);
        bus.op    = 3'd5;
        bus.a     = W'(15);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("abort_busy1", int'(bus.busy), 1);
        step();
        check("abort_busy2", int'(bus.busy), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_res = 0;
        check("abort_result", int'(bus.result), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check_flags("abort_flags");
        step();
        check("abort_quiet", int'(bus.result), 0);
        do_op(0, 1, 1'b0);
        check("post_abort", int'(bus.result), 8'h01);

        // Randomized operations against the model.
        for (int i = 0; i < 80; i++) begin
            do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, WM)), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                step();
                check("rnd_idle_done", int'(bus.done), 0);
                check("rnd_idle_hold", int'(bus.result), m_res);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
